// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared Ethernet receive constants, FSM state type and CRC helpers
package eth_rx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // CRC-32 (IEEE 802.3), processed reflected / LSB-first
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  // Register value left after running data plus a correct FCS through the CRC
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DROP
  } rx_state_e;

  // Bit-reverse a 32-bit word; turns the normal polynomial into its LSB-first form
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_d8.sv
// rtl/eth_crc32_d8.sv - combinational CRC-32 update for one byte, LSB-first
module eth_crc32_d8
  import eth_rx_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] POLY_REFL = reflect32(CRC_POLY);

  // Eight serial LFSR steps unrolled, data bit 0 enters first
  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_o[0] ^ data_i[i]) begin
        crc_o = (crc_o >> 1) ^ POLY_REFL;
      end else begin
        crc_o = crc_o >> 1;
      end
    end
  end

endmodule

// File: rtl/gmii_rx_frame_parser.sv
// rtl/gmii_rx_frame_parser.sv - strips preamble/SFD/FCS, checks CRC and length, emits payload stream
module gmii_rx_frame_parser
  import eth_rx_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_stb,
  input  logic [7:0]       gmii_rxd,
  output logic [7:0]       m_data,
  output logic             m_valid,
  output logic             m_last,
  output logic             m_err,
  output logic [CNT_W-1:0] frame_ok_cnt,
  output logic [CNT_W-1:0] frame_err_cnt
);

  rx_state_e        state_q, state_d;
  logic [31:0]      crc_q, crc_d, crc_next;
  logic [15:0]      len_q, len_d;
  logic [4:0][7:0]  dl_q, dl_d;          // [0] newest, [4] oldest
  logic [2:0]       dl_cnt_q, dl_cnt_d;  // number of valid delay-line entries
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             m_err_q, m_err_d;
  logic [CNT_W-1:0] ok_cnt_q, ok_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             ok_inc, err_inc;
  logic             frame_bad;

  eth_crc32_d8 u_crc (
    .crc_i  (crc_q),
    .data_i (gmii_rxd),
    .crc_o  (crc_next)
  );

  // Verdict for the frame currently ending: FCS mismatch or illegal length
  always_comb begin
    frame_bad = (crc_q != CRC_RESIDUE)
              || (32'(len_q) < 32'(MIN_LEN))
              || (32'(len_q) > 32'(MAX_LEN));
  end

  // Next-state, datapath and output decode for the receive FSM
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    len_d     = len_q;
    dl_d      = dl_q;
    dl_cnt_d  = dl_cnt_q;
    m_data_d  = m_data_q;
    m_valid_d = 1'b0;
    m_last_d  = 1'b0;
    m_err_d   = 1'b0;
    ok_inc    = 1'b0;
    err_inc   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (gmii_rx_dv && gmii_rx_stb) begin
          state_d = (gmii_rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
        end
      end

      ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
          err_inc = 1'b1;
        end else if (gmii_rx_stb) begin
          if (gmii_rxd == SFD_BYTE) begin
            state_d  = ST_DATA;
            crc_d    = CRC_INIT;
            len_d    = '0;
            dl_cnt_d = '0;
          end else if (gmii_rxd != PREAMBLE_BYTE) begin
            state_d = ST_DROP;
          end
        end
      end

      ST_DATA: begin
        if (!gmii_rx_dv) begin
          state_d  = ST_IDLE;
          dl_cnt_d = '0;
          if (dl_cnt_q == 3'd5) begin
            // Oldest entry is the last payload byte; the other four are the FCS
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            m_data_d  = dl_q[4];
            m_err_d   = frame_bad;
            ok_inc    = !frame_bad;
            err_inc   = frame_bad;
          end else begin
            err_inc = 1'b1;
          end
        end else if (gmii_rx_stb) begin
          crc_d = crc_next;
          len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
          dl_d  = {dl_q[3:0], gmii_rxd};
          if (dl_cnt_q == 3'd5) begin
            m_valid_d = 1'b1;
            m_data_d  = dl_q[4];
          end else begin
            dl_cnt_d = dl_cnt_q + 3'd1;
          end
        end
      end

      ST_DROP: begin
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
          err_inc = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Saturating statistics counters
  always_comb begin
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    if (ok_inc && (ok_cnt_q != {CNT_W{1'b1}})) begin
      ok_cnt_d = ok_cnt_q + CNT_W'(1);
    end
    if (err_inc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  // State and datapath registers; reset abandons any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      crc_q     <= CRC_INIT;
      len_q     <= '0;
      dl_q      <= '0;
      dl_cnt_q  <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_err_q   <= 1'b0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      dl_q      <= dl_d;
      dl_cnt_q  <= dl_cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_err_q   <= m_err_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_data        = m_data_q;
  assign m_valid       = m_valid_q;
  assign m_last        = m_last_q;
  assign m_err         = m_err_q;
  assign frame_ok_cnt  = ok_cnt_q;
  assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_gmii_rx_frame_parser.sv
// tb/tb_gmii_rx_frame_parser.sv - scoreboard bench for gmii_rx_frame_parser
module tb_gmii_rx_frame_parser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        gmii_rx_dv;
  logic        gmii_rx_stb;
  logic [7:0]  gmii_rxd;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_err;
  logic [15:0] frame_ok_cnt;
  logic [15:0] frame_err_cnt;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       err;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] frm[$];
  int         checks   = 0;
  int         failures = 0;
  int         ok_exp   = 0;
  int         err_exp  = 0;

  always #5 clk = ~clk;

  gmii_rx_frame_parser #(
    .MIN_LEN (64),
    .MAX_LEN (1518),
    .CNT_W   (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .gmii_rx_dv    (gmii_rx_dv),
    .gmii_rx_stb   (gmii_rx_stb),
    .gmii_rxd      (gmii_rxd),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_err         (m_err),
    .frame_ok_cnt  (frame_ok_cnt),
    .frame_err_cnt (frame_err_cnt)
  );

  // Reference CRC-32: byte-wide xor then eight shifts
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive frm[] with one idle cycle between strobes, then hold dv low for gap cycles
  task automatic send_frame(input int gap);
    gmii_rx_dv = 1'b1;
    foreach (frm[i]) begin
      gmii_rx_stb = 1'b1;
      gmii_rxd    = frm[i];
      tick();
      gmii_rx_stb = 1'b0;
      tick();
    end
    gmii_rx_dv = 1'b0;
    repeat (gap) tick();
  endtask

  // Preamble, SFD, payload 0,1,2..., FCS; queue the expected beats and verdict
  task automatic build_good(input int plen, input bit corrupt);
    logic [31:0] c;
    logic [31:0] fcs;
    int          len;
    bit          bad;
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    c = 32'hFFFFFFFF;
    for (int i = 0; i < plen; i++) begin
      frm.push_back(8'(i));
      c = crc_upd(c, 8'(i));
    end
    fcs = ~c;
    frm.push_back(fcs[7:0]);
    frm.push_back(fcs[15:8]);
    frm.push_back(fcs[23:16]);
    frm.push_back(fcs[31:24]);
    if (corrupt) frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    len = plen + 4;
    bad = corrupt || (len < 64) || (len > 1518);
    for (int i = 0; i < plen; i++) begin
      exp_q.push_back('{d: 8'(i), last: (i == plen - 1), err: bad});
    end
    if (bad) err_exp++;
    else ok_exp++;
  endtask

  task automatic check_after(input string name);
    repeat (3) tick();
    chk({name, "_drained"}, exp_q.size(), 0);
    chk({name, "_ok_cnt"}, int'(frame_ok_cnt), ok_exp);
    chk({name, "_err_cnt"}, int'(frame_err_cnt), err_exp);
  endtask

  // Monitor: every output beat is matched against the head of the scoreboard
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got d=%02h last=%0b err=%0b expected none",
                   m_data, m_last, m_err);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.d || m_last !== e.last || (e.last && m_err !== e.err)) begin
            failures++;
            $display("FAIL beat got d=%02h last=%0b err=%0b expected d=%02h last=%0b err=%0b",
                     m_data, m_last, m_err, e.d, e.last, e.err);
          end
        end
      end
    end
  end

  initial begin
    logic [31:0] c;
    logic [7:0]  s[9];
    rst_n       = 1'b0;
    gmii_rx_dv  = 1'b0;
    gmii_rx_stb = 1'b0;
    gmii_rxd    = 8'h00;
    repeat (3) tick();
    chk("reset_m_valid", int'(m_valid), 0);
    chk("reset_m_last", int'(m_last), 0);
    chk("reset_m_err", int'(m_err), 0);
    chk("reset_m_data", int'(m_data), 0);
    chk("reset_ok_cnt", int'(frame_ok_cnt), 0);
    chk("reset_err_cnt", int'(frame_err_cnt), 0);
    rst_n = 1'b1;
    tick();

    // Reference model sanity: CRC-32 of "123456789" is 0xCBF43926
    s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    c = 32'hFFFFFFFF;
    foreach (s[i]) c = crc_upd(c, s[i]);
    checks++;
    if (~c != 32'hCBF43926) begin
      failures++;
      $display("FAIL crc_model got=%08h expected=cbf43926", ~c);
    end

    // Good 64-byte frame
    build_good(60, 1'b0);
    send_frame(4);
    check_after("good64");

    // Same frame, FCS corrupted
    build_good(60, 1'b1);
    send_frame(4);
    check_after("bad_fcs");

    // Broken preamble: whole frame dropped
    frm.delete();
    frm.push_back(8'h55);
    frm.push_back(8'h55);
    frm.push_back(8'hAA);
    for (int i = 0; i < 70; i++) frm.push_back(8'(i + 3));
    err_exp++;
    send_frame(4);
    check_after("bad_preamble");

    // Runt: SFD plus three bytes
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    frm.push_back(8'h11);
    frm.push_back(8'h22);
    frm.push_back(8'h33);
    err_exp++;
    send_frame(4);
    check_after("runt3");

    // 20-byte frame, valid FCS but too short
    build_good(16, 1'b0);
    send_frame(4);
    check_after("short20");

    // 1600-byte frame, streamed in full, flagged oversize
    build_good(1596, 1'b0);
    send_frame(4);
    check_after("long1600");

    // Two minimum frames separated by a single dv-low cycle
    build_good(60, 1'b0);
    send_frame(1);
    build_good(60, 1'b0);
    send_frame(4);
    check_after("back2back");

    // Reset after 30 payload bytes: 25 beats already out, then silence
    frm.delete();
    repeat (7) frm.push_back(8'h55);
    frm.push_back(8'hD5);
    for (int i = 0; i < 30; i++) frm.push_back(8'(i));
    for (int i = 0; i < 25; i++) exp_q.push_back('{d: 8'(i), last: 1'b0, err: 1'b0});
    gmii_rx_dv = 1'b1;
    foreach (frm[i]) begin
      gmii_rx_stb = 1'b1;
      gmii_rxd    = frm[i];
      tick();
      gmii_rx_stb = 1'b0;
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_m_valid", int'(m_valid), 0);
    chk("midreset_m_last", int'(m_last), 0);
    chk("midreset_ok_cnt", int'(frame_ok_cnt), 0);
    chk("midreset_err_cnt", int'(frame_err_cnt), 0);
    chk("midreset_drained", exp_q.size(), 0);
    gmii_rx_dv = 1'b0;
    repeat (2) tick();
    rst_n   = 1'b1;
    ok_exp  = 0;
    err_exp = 0;
    tick();
    build_good(60, 1'b0);
    send_frame(4);
    check_after("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
